rob: RTL and testbench

Reorder buffer for the out-of-order core. It allocates one entry per renamed instruction and sends the tag (physical address) to the register alias table, which stores it as the rename. It accepts execution writebacks by tag, supplies source-operand values to the issue stage, and retires entries in program order. On retirement it drives the alias table's commit and flush inputs.

---
 rtl/rob.sv | 146 ++++++++++++++
 tb/tb_rob.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: allocates entries in rename order, collects writebacks by tag,
// serves operand reads, and retires in program order while driving RAT commit/flush.
module rob #(
   parameter int ROB_DEPTH      = 8,
   parameter int GPR_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH     = 32,
   localparam int TW            = $clog2(ROB_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      alloc_req,
   input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
   input  logic                      alloc_dst_wen,
   output logic                      allocate_en,
   output logic [TW-1:0]             rob_alloc_tag_2rat,
   output logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr_2rat,
   output logic                      rob_alloc_dst_wen_2rat,
   output logic                      rob_full,
   output logic                      rob_empty,
   input  logic                      wb_en,
   input  logic [TW-1:0]             wb_tag,
   input  logic [DATA_WIDTH-1:0]     wb_data,
   input  logic                      wb_br_taken,
   input  logic                      wb_exp_en,
   input  logic [TW-1:0]             rs1_Paddr,
   input  logic [TW-1:0]             rs2_Paddr,
   output logic                      rob_rs1_ready,
   output logic                      rob_rs2_ready,
   output logic [DATA_WIDTH-1:0]     rob_rs1_data,
   output logic [DATA_WIDTH-1:0]     rob_rs2_data,
   output logic                      commit_valid,
   output logic                      commit_dst_en,
   output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr_2rat,
   output logic [TW-1:0]             rob_commit_Paddr,
   output logic [DATA_WIDTH-1:0]     rob_commit_data,
   output logic                      rob_commit_br_taken,
   output logic                      rob_commit_exp_en
);

   localparam logic [TW:0] FULL_CNT = ROB_DEPTH[TW:0];

   logic [ROB_DEPTH-1:0]      valid_r;
   logic [ROB_DEPTH-1:0]      done_r;
   logic [ROB_DEPTH-1:0]      dst_wen_r;
   logic [ROB_DEPTH-1:0]      br_taken_r;
   logic [ROB_DEPTH-1:0]      exp_r;
   logic [GPR_ADDR_WIDTH-1:0] dst_addr_r [ROB_DEPTH];
   logic [DATA_WIDTH-1:0]     data_r     [ROB_DEPTH];
   logic [TW-1:0]             head_r;
   logic [TW-1:0]             tail_r;
   logic [TW:0]               count_r;

   logic commit_s;
   logic flush_s;
   logic alloc_s;

   // Retire/flush/allocate decisions from current state and request
   always_comb begin
      commit_s = valid_r[head_r] && done_r[head_r];
      flush_s  = commit_s && (br_taken_r[head_r] || exp_r[head_r]);
      alloc_s  = alloc_req && (count_r != FULL_CNT) && !flush_s;
   end

   // Combinational output drive: allocation, status, operand reads, commit
   always_comb begin
      allocate_en              = alloc_s;
      rob_alloc_tag_2rat       = tail_r;
      rob_alloc_dst_addr_2rat  = alloc_dst_addr;
      rob_alloc_dst_wen_2rat   = alloc_dst_wen;
      rob_full                 = (count_r == FULL_CNT);
      rob_empty                = (count_r == '0);
      rob_rs1_ready            = valid_r[rs1_Paddr] && done_r[rs1_Paddr];
      rob_rs2_ready            = valid_r[rs2_Paddr] && done_r[rs2_Paddr];
      rob_rs1_data             = data_r[rs1_Paddr];
      rob_rs2_data             = data_r[rs2_Paddr];
      commit_valid             = commit_s;
      // A taken branch still writes its link register; only exceptions suppress
      commit_dst_en            = commit_s && dst_wen_r[head_r] && !exp_r[head_r];
      rob_commit_dst_addr_2rat = dst_addr_r[head_r];
      rob_commit_Paddr         = head_r;
      rob_commit_data          = data_r[head_r];
      rob_commit_br_taken      = commit_s && br_taken_r[head_r];
      rob_commit_exp_en        = commit_s && exp_r[head_r];
   end

   // Head/tail pointers and occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else if (flush_s) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         if (commit_s) begin
            head_r <= head_r + TW'(1);
         end
         if (alloc_s) begin
            tail_r <= tail_r + TW'(1);
         end
         if (alloc_s && !commit_s) begin
            count_r <= count_r + (TW+1)'(1);
         end else if (commit_s && !alloc_s) begin
            count_r <= count_r - (TW+1)'(1);
         end
      end
   end

   // Per-entry state: allocate at tail, retire at head, writeback by tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r    <= '0;
         done_r     <= '0;
         dst_wen_r  <= '0;
         br_taken_r <= '0;
         exp_r      <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            dst_addr_r[i] <= '0;
            data_r[i]     <= '0;
         end
      end else begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            if (flush_s) begin
               valid_r[i] <= 1'b0;
            end else if (alloc_s && (tail_r == TW'(i))) begin
               valid_r[i]    <= 1'b1;
               done_r[i]     <= 1'b0;
               br_taken_r[i] <= 1'b0;
               exp_r[i]      <= 1'b0;
               dst_addr_r[i] <= alloc_dst_addr;
               dst_wen_r[i]  <= alloc_dst_wen;
            end else if (commit_s && (head_r == TW'(i))) begin
               valid_r[i] <= 1'b0;
            end else if (wb_en && valid_r[i] && (wb_tag == TW'(i))) begin
               done_r[i]     <= 1'b1;
               data_r[i]     <= wb_data;
               br_taken_r[i] <= wb_br_taken;
               exp_r[i]      <= wb_exp_en;
            end
         end
      end
   end

endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed vector table, corner-case sequences, and random traffic
// checked against a queue-based program-order model.
module tb_rob;
   localparam int D  = 8;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int TW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          alloc_req, alloc_dst_wen, allocate_en, rob_alloc_dst_wen_2rat;
   logic [AW-1:0] alloc_dst_addr, rob_alloc_dst_addr_2rat, rob_commit_dst_addr_2rat;
   logic [TW-1:0] rob_alloc_tag_2rat, wb_tag, rs1_Paddr, rs2_Paddr, rob_commit_Paddr;
   logic          rob_full, rob_empty, wb_en, wb_br_taken, wb_exp_en;
   logic [DW-1:0] wb_data, rob_rs1_data, rob_rs2_data, rob_commit_data;
   logic          rob_rs1_ready, rob_rs2_ready, commit_valid, commit_dst_en;
   logic          rob_commit_br_taken, rob_commit_exp_en;

   rob #(.ROB_DEPTH(D), .GPR_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_req(alloc_req), .alloc_dst_addr(alloc_dst_addr), .alloc_dst_wen(alloc_dst_wen),
      .allocate_en(allocate_en), .rob_alloc_tag_2rat(rob_alloc_tag_2rat),
      .rob_alloc_dst_addr_2rat(rob_alloc_dst_addr_2rat),
      .rob_alloc_dst_wen_2rat(rob_alloc_dst_wen_2rat),
      .rob_full(rob_full), .rob_empty(rob_empty),
      .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
      .wb_br_taken(wb_br_taken), .wb_exp_en(wb_exp_en),
      .rs1_Paddr(rs1_Paddr), .rs2_Paddr(rs2_Paddr),
      .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
      .rob_rs1_data(rob_rs1_data), .rob_rs2_data(rob_rs2_data),
      .commit_valid(commit_valid), .commit_dst_en(commit_dst_en),
      .rob_commit_dst_addr_2rat(rob_commit_dst_addr_2rat),
      .rob_commit_Paddr(rob_commit_Paddr), .rob_commit_data(rob_commit_data),
      .rob_commit_br_taken(rob_commit_br_taken), .rob_commit_exp_en(rob_commit_exp_en)
   );

   // Reference model: in-flight instructions in program order
   typedef struct {
      logic [TW-1:0] tag;
      logic [AW-1:0] dst;
      logic          wen;
      logic          done;
      logic [DW-1:0] data;
      logic          br;
      logic          ex;
   } ment_t;

   ment_t         mq[$];
   logic [TW-1:0] m_next;
   int            n_vec = 0;
   int            n_err = 0;

   typedef struct {
      logic          req;
      logic [AW-1:0] dst;
      logic          wen;
      logic          wbe;
      logic [TW-1:0] wtag;
      logic [DW-1:0] wdata;
      logic          br;
      logic [TW-1:0] r1;
      logic          e_alloc;
      logic [TW-1:0] e_tag;
      logic          e_empty;
      logic          e_cv;
      logic          e_cde;
      logic [AW-1:0] e_cdst;
      logic [DW-1:0] e_cdata;
      logic          e_cbr;
      logic          e_rdy1;
   } vec_t;

   vec_t tbl[10];

   function automatic vec_t mk(input logic req, input logic [AW-1:0] dst, input logic wen,
                               input logic wbe, input logic [TW-1:0] wtag,
                               input logic [DW-1:0] wdata, input logic br,
                               input logic [TW-1:0] r1, input logic e_alloc,
                               input logic [TW-1:0] e_tag, input logic e_empty,
                               input logic e_cv, input logic e_cde, input logic [AW-1:0] e_cdst,
                               input logic [DW-1:0] e_cdata, input logic e_cbr,
                               input logic e_rdy1);
      vec_t v;
      v.req = req; v.dst = dst; v.wen = wen; v.wbe = wbe; v.wtag = wtag; v.wdata = wdata;
      v.br = br; v.r1 = r1; v.e_alloc = e_alloc; v.e_tag = e_tag; v.e_empty = e_empty;
      v.e_cv = e_cv; v.e_cde = e_cde; v.e_cdst = e_cdst; v.e_cdata = e_cdata;
      v.e_cbr = e_cbr; v.e_rdy1 = e_rdy1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int find(input logic [TW-1:0] t);
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].tag == t) return i;
      end
      return -1;
   endfunction

   function automatic bit m_cv();
      return (mq.size() > 0) && mq[0].done;
   endfunction

   function automatic bit m_flush();
      return m_cv() && (mq[0].br || mq[0].ex);
   endfunction

   function automatic bit m_alloc();
      return alloc_req && (mq.size() < D) && !m_flush();
   endfunction

   task automatic check_model();
      bit            cv;
      int            k;
      bit            rdy;
      logic [TW-1:0] head;
      cv   = m_cv();
      head = (mq.size() > 0) ? mq[0].tag : m_next;
      chk("allocate_en", allocate_en, m_alloc());
      chk("alloc_tag", rob_alloc_tag_2rat, m_next);
      chk("alloc_dst_copy", rob_alloc_dst_addr_2rat, alloc_dst_addr);
      chk("alloc_wen_copy", rob_alloc_dst_wen_2rat, alloc_dst_wen);
      chk("rob_full", rob_full, mq.size() == D);
      chk("rob_empty", rob_empty, mq.size() == 0);
      chk("commit_valid", commit_valid, cv);
      chk("commit_Paddr", rob_commit_Paddr, head);
      if (cv) begin
         chk("commit_dst_en", commit_dst_en, mq[0].wen && !mq[0].ex);
         chk("commit_dst", rob_commit_dst_addr_2rat, mq[0].dst);
         chk("commit_data", rob_commit_data, mq[0].data);
         chk("commit_br", rob_commit_br_taken, mq[0].br);
         chk("commit_exp", rob_commit_exp_en, mq[0].ex);
      end else begin
         chk("commit_dst_en_idle", commit_dst_en, 1'b0);
         chk("commit_br_idle", rob_commit_br_taken, 1'b0);
         chk("commit_exp_idle", rob_commit_exp_en, 1'b0);
      end
      k   = find(rs1_Paddr);
      rdy = (k >= 0) && mq[k].done;
      chk("rs1_ready", rob_rs1_ready, rdy);
      if (rdy) chk("rs1_data", rob_rs1_data, mq[k].data);
      k   = find(rs2_Paddr);
      rdy = (k >= 0) && mq[k].done;
      chk("rs2_ready", rob_rs2_ready, rdy);
      if (rdy) chk("rs2_data", rob_rs2_data, mq[k].data);
   endtask

   task automatic model_tick();
      bit    cv, fl, al;
      int    k;
      ment_t e;
      cv = m_cv();
      fl = m_flush();
      al = m_alloc();
      if (fl) begin
         mq.delete();
         m_next = '0;
      end else begin
         if (wb_en) begin
            k = find(wb_tag);
            if (k >= 0) begin
               mq[k].done = 1'b1;
               mq[k].data = wb_data;
               mq[k].br   = wb_br_taken;
               mq[k].ex   = wb_exp_en;
            end
         end
         if (cv) void'(mq.pop_front());
         if (al) begin
            e.tag = m_next; e.dst = alloc_dst_addr; e.wen = alloc_dst_wen;
            e.done = 1'b0; e.data = '0; e.br = 1'b0; e.ex = 1'b0;
            mq.push_back(e);
            m_next = m_next + 3'd1;
         end
      end
   endtask

   task automatic set_idle();
      alloc_req = 1'b0; alloc_dst_addr = '0; alloc_dst_wen = 1'b0;
      wb_en = 1'b0; wb_tag = '0; wb_data = '0; wb_br_taken = 1'b0; wb_exp_en = 1'b0;
      rs1_Paddr = '0; rs2_Paddr = '0;
   endtask

   task automatic apply(input logic req, input logic [AW-1:0] dst, input logic wen,
                        input logic wbe, input logic [TW-1:0] wtag, input logic [DW-1:0] wdata,
                        input logic br, input logic ex,
                        input logic [TW-1:0] r1, input logic [TW-1:0] r2);
      @(negedge clk);
      alloc_req = req; alloc_dst_addr = dst; alloc_dst_wen = wen;
      wb_en = wbe; wb_tag = wtag; wb_data = wdata; wb_br_taken = br; wb_exp_en = ex;
      rs1_Paddr = r1; rs2_Paddr = r2;
      #1;
      check_model();
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
   endtask

   // Asynchronous reset asserted in the middle of a cycle, released on a falling edge
   task automatic reset_dut();
      @(negedge clk);
      set_idle();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_empty", rob_empty, 1'b1);
      chk("rst_full", rob_full, 1'b0);
      chk("rst_commit_valid", commit_valid, 1'b0);
      chk("rst_commit_dst_en", commit_dst_en, 1'b0);
      chk("rst_commit_br", rob_commit_br_taken, 1'b0);
      chk("rst_commit_exp", rob_commit_exp_en, 1'b0);
      chk("rst_rs1_ready", rob_rs1_ready, 1'b0);
      chk("rst_rs2_ready", rob_rs2_ready, 1'b0);
      chk("rst_alloc_tag", rob_alloc_tag_2rat, 3'd0);
      mq.delete();
      m_next = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t t;
      set_idle();
      m_next = '0;
      //          req dst wen wbe wtag wdata  br r1  al tag emp cv cde cdst cdata  cbr rdy1
      tbl[0] = mk(1,  5,  1,  0,  0,   0,     0, 0,  1, 0,  1,  0, 0,  0,   0,     0,  0);
      tbl[1] = mk(1,  6,  1,  0,  0,   0,     0, 0,  1, 1,  0,  0, 0,  0,   0,     0,  0);
      tbl[2] = mk(1,  7,  1,  0,  0,   0,     0, 0,  1, 2,  0,  0, 0,  0,   0,     0,  0);
      tbl[3] = mk(0,  0,  0,  1,  1,   'h11,  0, 1,  0, 3,  0,  0, 0,  0,   0,     0,  0);
      tbl[4] = mk(0,  0,  0,  1,  0,   'hA,   0, 1,  0, 3,  0,  0, 0,  0,   0,     0,  1);
      tbl[5] = mk(0,  0,  0,  0,  0,   0,     0, 0,  0, 3,  0,  1, 1,  5,   'hA,   0,  1);
      tbl[6] = mk(0,  0,  0,  0,  0,   0,     0, 0,  0, 3,  0,  1, 1,  6,   'h11,  0,  0);
      tbl[7] = mk(0,  0,  0,  1,  2,   'h22,  1, 2,  0, 3,  0,  0, 0,  0,   0,     0,  0);
      tbl[8] = mk(1,  8,  1,  0,  0,   0,     0, 2,  0, 3,  0,  1, 1,  7,   'h22,  1,  1);
      tbl[9] = mk(1,  9,  1,  0,  0,   0,     0, 0,  1, 0,  1,  0, 0,  0,   0,     0,  0);

      reset_dut();

      // Basic flow, in-order retirement, taken-branch flush
      for (int i = 0; i < 10; i++) begin
         t = tbl[i];
         apply(t.req, t.dst, t.wen, t.wbe, t.wtag, t.wdata, t.br, 1'b0, t.r1, 3'd0);
         chk("tbl_alloc_en", allocate_en, t.e_alloc);
         chk("tbl_tag", rob_alloc_tag_2rat, t.e_tag);
         chk("tbl_empty", rob_empty, t.e_empty);
         chk("tbl_commit_valid", commit_valid, t.e_cv);
         chk("tbl_commit_dst_en", commit_dst_en, t.e_cde);
         chk("tbl_commit_br", rob_commit_br_taken, t.e_cbr);
         chk("tbl_rs1_ready", rob_rs1_ready, t.e_rdy1);
         if (t.e_cv) begin
            chk("tbl_commit_dst", rob_commit_dst_addr_2rat, t.e_cdst);
            chk("tbl_commit_data", rob_commit_data, t.e_cdata);
         end
         tick();
      end

      // Fill to full, reject a ninth request, then wrap the tail
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         apply(1'b1, AW'(i + 1), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
         chk("fill_tag", rob_alloc_tag_2rat, i);
         tick();
      end
      apply(1'b1, 5'd20, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      chk("full_flag", rob_full, 1'b1);
      chk("full_reject", allocate_en, 1'b0);
      tick();
      apply(1'b0, '0, 1'b0, 1'b1, 3'd0, 32'h55, 1'b0, 1'b0, '0, '0);
      tick();
      apply(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      chk("wrap_commit", commit_valid, 1'b1);
      chk("wrap_commit_data", rob_commit_data, 32'h55);
      tick();
      apply(1'b1, 5'd21, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      chk("wrap_alloc_en", allocate_en, 1'b1);
      chk("wrap_tag", rob_alloc_tag_2rat, 3'd0);
      tick();

      // Simultaneous allocate and commit at count 4
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, AW'(i + 10), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
         tick();
      end
      apply(1'b0, '0, 1'b0, 1'b1, 3'd0, 32'hBEEF, 1'b0, 1'b0, '0, '0);
      tick();
      apply(1'b1, 5'd14, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      chk("sim_commit", commit_valid, 1'b1);
      chk("sim_alloc", allocate_en, 1'b1);
      chk("sim_tag", rob_alloc_tag_2rat, 3'd4);
      chk("sim_head", rob_commit_Paddr, 3'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, AW'(i + 15), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
         if (i == 0) chk("sim_head_next", rob_commit_Paddr, 3'd1);
         chk("sim_not_full", rob_full, 1'b0);
         tick();
      end
      apply(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      chk("sim_full_after4", rob_full, 1'b1);
      tick();

      // Exception retire suppresses the register write; stray writeback ignored
      reset_dut();
      apply(1'b1, 5'd9, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      tick();
      apply(1'b1, 5'd10, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      tick();
      apply(1'b0, '0, 1'b0, 1'b1, 3'd0, 32'h99, 1'b0, 1'b1, '0, '0);
      tick();
      apply(1'b1, 5'd3, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      chk("exp_commit", commit_valid, 1'b1);
      chk("exp_dst_en", commit_dst_en, 1'b0);
      chk("exp_flag", rob_commit_exp_en, 1'b1);
      chk("exp_alloc_dropped", allocate_en, 1'b0);
      tick();
      apply(1'b0, '0, 1'b0, 1'b1, 3'd5, 32'h77, 1'b0, 1'b0, '0, '0);
      chk("exp_empty_after", rob_empty, 1'b1);
      tick();
      apply(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 3'd5, 3'd5);
      chk("stray_wb_ready", rob_rs1_ready, 1'b0);
      tick();

      // Reset mid-run with five entries in flight
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, AW'(i + 1), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
         tick();
      end
      apply(1'b0, '0, 1'b0, 1'b1, 3'd0, 32'h1234, 1'b0, 1'b0, '0, '0);
      tick();
      reset_dut();
      apply(1'b1, 5'd2, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      chk("post_reset_tag", rob_alloc_tag_2rat, 3'd0);
      chk("post_reset_alloc", allocate_en, 1'b1);
      tick();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic [TW-1:0] wt;
         if ((mq.size() > 0) && ($urandom_range(0, 7) != 0))
            wt = mq[$urandom_range(0, mq.size() - 1)].tag;
         else
            wt = TW'($urandom_range(0, D - 1));
         apply($urandom_range(0, 3) != 0, AW'($urandom), 1'($urandom),
               1'($urandom), wt, $urandom,
               $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
               TW'($urandom), TW'($urandom));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
